// File: rtl/iommu_reg_hw_wr_arb.sv
// iommu_reg_hw_wr_arb
//   Shares the hardware write port (de/d) of the IOMMU register field bank
//   among N_REQ hardware update sources. One requester is picked round-robin,
//   and its field index and data are captured. A single one-cycle de pulse is
//   then driven to that field. A same-cycle software write to the same field
//   wins, and the hardware write is retried on the following cycle.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req_valid_i       per-requester request, held until acked
//   req_sel_i         packed field index, requester i at [i*SEL_W +: SEL_W]
//   req_data_i        packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack_o         one-hot pulse, the write commits this cycle
//   sw_we_i, sw_sel_i software write to the bank this cycle
//   hw_de_o           hardware write enable
//   hw_sel_o, hw_d_o  captured field index / data
//   busy_o            a captured request is pending
//   stall_cnt_o       (IOMMU_HWARB_STALL_CNT_EN) saturating collision-cycle count
//   stall_o           (IOMMU_HWARB_STALL_CNT_EN) high on each collision cycle
//
// Optional feature macro: IOMMU_HWARB_STALL_CNT_EN

`timescale 1ns/1ps

module iommu_reg_hw_wr_arb #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_FIELDS   = 16,
  localparam int unsigned SEL_W     = $clog2(N_FIELDS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*SEL_W-1:0]      req_sel_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ack_o,
  input  logic                        sw_we_i,
  input  logic [SEL_W-1:0]            sw_sel_i,
  output logic                        hw_de_o,
  output logic [SEL_W-1:0]            hw_sel_o,
  output logic [DATA_WIDTH-1:0]       hw_d_o,
`ifdef IOMMU_HWARB_STALL_CNT_EN
  output logic [15:0]                 stall_cnt_o,
  output logic                        stall_o,
`endif
  output logic                        busy_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e                state_q;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic [PTR_W-1:0]      win_q;
  logic [SEL_W-1:0]      sel_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  any_valid;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W:0]        cand_sum;
  logic [PTR_W-1:0]      cand;
  logic                  collision;
  logic                  commit;
  logic [PTR_W-1:0]      win_next;

  // Scan from rr_ptr upward, wrapping modulo N_REQ; first valid wins.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_sum >= (PTR_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (PTR_W+1)'(N_REQ);
      end
      cand = cand_sum[PTR_W-1:0];
      if (!any_valid && req_valid_i[cand]) begin
        any_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Only registered state, the captured select and the software port feed
  // de/ack, so there is no path from req_* to any output.
  assign collision = (state_q == ISSUE) && sw_we_i && (sw_sel_i == sel_q);
  assign commit    = (state_q == ISSUE) && !collision;
  assign win_next  = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      sel_q    <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            win_q   <= win_idx;
            sel_q   <= req_sel_i[win_idx*SEL_W +: SEL_W];
            data_q  <= req_data_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (commit) begin
            rr_ptr_q <= win_next;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ack_o        = '0;
    req_ack_o[win_q] = commit;
  end

  assign hw_de_o  = commit;
  assign hw_sel_o = sel_q;
  assign hw_d_o   = data_q;
  assign busy_o   = (state_q == ISSUE);

`ifdef IOMMU_HWARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (collision && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign stall_o     = collision;
`endif

endmodule

// File: tb/tb_iommu_reg_hw_wr_arb.sv
`timescale 1ns/1ps

module tb_iommu_reg_hw_wr_arb;

  localparam int N  = 4;
  localparam int SW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*SW-1:0] req_sel = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    ack;
  logic            sw_we = 1'b0;
  logic [SW-1:0]   sw_sel = '0;
  logic            de;
  logic [SW-1:0]   hsel;
  logic [DW-1:0]   hd;
  logic            busy;
`ifdef IOMMU_HWARB_STALL_CNT_EN
  logic [15:0]     stall_cnt;
  logic            stall;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iommu_reg_hw_wr_arb #(.N_REQ(N), .DATA_WIDTH(DW), .N_FIELDS(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_sel_i   (req_sel),
    .req_data_i  (req_data),
    .req_ack_o   (ack),
    .sw_we_i     (sw_we),
    .sw_sel_i    (sw_sel),
    .hw_de_o     (de),
    .hw_sel_o    (hsel),
    .hw_d_o      (hd),
`ifdef IOMMU_HWARB_STALL_CNT_EN
    .stall_cnt_o (stall_cnt),
    .stall_o     (stall),
`endif
    .busy_o      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending write (or none), a round-robin start index,
  // and the last captured field/data.
  bit            m_pend;
  int            m_win;
  int            m_rr;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_data;
  int            m_stall;

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic bit m_blocked();
    return m_pend && sw_we && (sw_sel == m_sel);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= 1'b0;
      m_win   <= 0;
      m_rr    <= 0;
      m_sel   <= '0;
      m_data  <= '0;
      m_stall <= 0;
    end else if (m_pend) begin
      if (!m_blocked()) begin
        m_pend <= 1'b0;
        m_rr   <= (m_win + 1) % N;
      end else if (m_stall < 65535) begin
        m_stall <= m_stall + 1;
      end
    end else if (pick(req_valid, m_rr) >= 0) begin
      m_pend <= 1'b1;
      m_win  <= pick(req_valid, m_rr);
      m_sel  <= req_sel[pick(req_valid, m_rr)*SW +: SW];
      m_data <= req_data[pick(req_valid, m_rr)*DW +: DW];
    end
  end

  // Commit log taken from the DUT's acks, checked against literals later.
  int            log_idx[$];
  logic [DW-1:0] log_dat[$];

  always @(negedge clk) begin
    if (rst_n) begin
      logic          exp_de;
      logic [N-1:0]  exp_ack;
      exp_de  = m_pend && !m_blocked();
      exp_ack = exp_de ? N'(1) << m_win : '0;
      check("de", 64'(de), 64'(exp_de));
      check("ack", 64'(ack), 64'(exp_ack));
      check("busy", 64'(busy), 64'(m_pend));
      check("hw_sel", 64'(hsel), 64'(m_sel));
      check("hw_d", 64'(hd), 64'(m_data));
`ifdef IOMMU_HWARB_STALL_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("stall", 64'(stall), 64'(m_blocked()));
`endif
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) log_idx.push_back(i);
        log_dat.push_back(hd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [SW-1:0] s, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_sel[i*SW +: SW]   = s;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    // Reset state
    tick();
    tick();
    check("rst_de", 64'(de), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sel", 64'(hsel), 64'd0);
    check("rst_d", 64'(hd), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single request from requester 2
    set_req(2, 4'd5, 32'hDEAD_BEEF);
    tick();
    check("t1_de", 64'(de), 64'd1);
    check("t1_sel", 64'(hsel), 64'd5);
    check("t1_d", 64'(hd), 64'hDEAD_BEEF);
    check("t1_ack", 64'(ack), 64'b0100);
    tick();
    req_valid = '0;
    check("t1_idle", 64'(busy), 64'd0);
    tick();

    // 2: all requesters held valid from reset
    do_reset();
    log_idx.delete();
    log_dat.delete();
    for (int i = 0; i < N; i++) set_req(i, SW'(i + 8), 32'h1000_0000 + DW'(i));
    for (int c = 0; c < 10; c++) tick();
    req_valid = '0;
    check("t2_count", 64'(log_idx.size()), 64'd5);
    if (log_idx.size() == 5) begin
      check("t2_o0", 64'(log_idx[0]), 64'd0);
      check("t2_o1", 64'(log_idx[1]), 64'd1);
      check("t2_o2", 64'(log_idx[2]), 64'd2);
      check("t2_o3", 64'(log_idx[3]), 64'd3);
      check("t2_o4", 64'(log_idx[4]), 64'd0);
      check("t2_d2", 64'(log_dat[2]), 64'h1000_0002);
    end
    tick();

    // 3: collision on field 7 for three cycles
    set_req(1, 4'd7, 32'h0000_00A5);
    tick();
    sw_we  = 1'b1;
    sw_sel = 4'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t3_de_blk", 64'(de), 64'd0);
      check("t3_ack_blk", 64'(ack), 64'd0);
      check("t3_busy", 64'(busy), 64'd1);
      tick();
    end
    sw_we = 1'b0;
    #1;
    check("t3_de", 64'(de), 64'd1);
    check("t3_ack", 64'(ack), 64'b0010);
`ifdef IOMMU_HWARB_STALL_CNT_EN
    check("t3_stall_cnt", 64'(stall_cnt), 64'd3);
`endif
    tick();
    req_valid = '0;
    tick();

    // 4: software write to a different field does not block
    set_req(0, 4'd7, 32'h0000_0044);
    tick();
    sw_we  = 1'b1;
    sw_sel = 4'd4;
    #1;
    check("t4_de", 64'(de), 64'd1);
    check("t4_ack", 64'(ack), 64'b0001);
    check("t4_sel", 64'(hsel), 64'd7);
    tick();
    sw_we     = 1'b0;
    req_valid = '0;
    tick();

    // 6: request inputs change after capture
    set_req(0, 4'd3, 32'h1);
    tick();
    req_data[0 +: DW] = 32'h2;
    req_sel[0 +: SW]  = 4'd9;
    #1;
    check("t6_d", 64'(hd), 64'h1);
    check("t6_sel", 64'(hsel), 64'd3);
    check("t6_de", 64'(de), 64'd1);
    tick();
    req_valid = '0;
    tick();

    // 5: asynchronous reset while a write is pending
    set_req(3, 4'd12, 32'h33);
    tick();
    check("t5_busy_pre", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_de", 64'(de), 64'd0);
    check("t5_ack", 64'(ack), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    tick();
    tick();
    rst_n  = 1'b1;
    waited = 0;
    while (ack == '0 && waited < 8) begin
      tick();
      waited++;
    end
    check("t5_wait", 64'(waited), 64'd1);
    check("t5_ack_re", 64'(ack), 64'b1000);
    check("t5_d_re", 64'(hd), 64'h33);
    tick();
    req_valid = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
